gfx_fb_write: RTL
=================

Name: gfx_fb_write

Overview:
- Consumer end of the fragment paint stream: accepts `frag_paint` beats (linear pixel index + ARGB color) from the fragment pipeline over a valid/ready handshake.
- Buffers them and issues single-beat Avalon-MM writes into the framebuffer at `fb_base + 4*linear`.
- Merges back-to-back writes to the same pixel while both are still queued.
- Sits between the fragment pipeline output and the memory interconnect; reports idle for frame-end synchronisation.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- ADDR_W, 19, width of linear_coord, the pixel index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  fragment beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in  in  $bits(frag_paint)  {linear[ADDR_W-1:0], color[31:0]}.
- fb_base  in  32  framebuffer byte base address; must be 4-byte aligned; sampled at push.
- mem_address  out  32  byte address of the write.
- mem_write  out  1  write request.
- mem_writedata  out  32  ARGB pixel.
- mem_byteenable  out  4  always 4'b1111.
- mem_waitrequest  in  1  interconnect stall.
- idle  out  1  FIFO empty and no write outstanding.
- frags_in  out  32  accepted beats, including merged ones.
- writes_out  out  32  completed memory writes.

Behaviour:
- Reset values: in_ready=0 during the rst cycle and 1 afterwards; mem_write=0; idle=1; frags_in=0; writes_out=0. Address and data outputs are don't-care while mem_write=0.
- Reset mid-write drops every queued entry. The interconnect must tolerate mem_write deasserting under waitrequest during reset.
- Entry format: {addr[31:0], color[31:0]}.
- Push address: addr = fb_base + (linear << 2), in 32-bit arithmetic that wraps modulo 2^32.
- Push occurs when in_valid && in_ready. in_ready = (count != DEPTH), purely registered state. There is no bypass when full, even if a pop happens the same cycle.
- Pop occurs when mem_write && !mem_waitrequest. mem_write = (count != 0).
- mem_address and mem_writedata always show the head entry. They stay stable while waitrequest is high, because the head only changes on pop.
- Latency: a beat pushed into an empty FIFO in cycle N drives mem_write in cycle N+1. With waitrequest low, the write completes in N+1, giving a throughput of 1 write per cycle.
- Merge rule:
  - Condition: push while count >= 2 and the computed addr equals the tail entry's addr.
  - Action: overwrite the tail color; count, wr_ptr and the FIFO contents other than the tail are unchanged.
  - Merging is never done into the head entry (count == 1), since that entry may already be on the bus.
  - A merge that coincides with a pop is legal: the pop removes the head, and the tail is still at a different index because count >= 2.
- Simultaneous push (non-merge) and pop: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Counters:
  - frags_in increments on every push, merged or not.
  - writes_out increments on every pop.
  - Both wrap modulo 2^32.
- idle = (count == 0).

Decomposition:
- gfx_defs package holds:
  - frag_paint (linear_coord linear; rgb32 color)
  - linear_coord, sized by a GFX_FB_ADDR_BITS define matching ADDR_W
  - rgb32
  - GFX_FB_WRITE_DEPTH, default DEPTH
- Sub-module gfx_fb_write_fifo:
  - DEPTH-entry circular buffer with push, pop and tail-overwrite ports.
  - Exposes head, tail and count.
- Top level holds address computation, merge compare, Avalon drive and counters.

Test Plan:
- Single beat: fb_base=0x1000_0000, linear=5, color=0xFF00FF00, waitrequest=0 → exactly one write the next cycle with address 0x1000_0014, data 0xFF00FF00, byteenable 0xF; then idle=1, frags_in=1, writes_out=1.
- Backpressure fill: waitrequest=1, push 8 beats with linear=0..7 → in_ready=0 after the 8th push; the head address is held stable for 20 cycles. Release waitrequest → 8 writes in order, 1 per cycle, with addresses base+0..base+28.
- Merge: waitrequest=1, push linear 1, 2, 2(color 0xA), 2(color 0xB) → count=2 and frags_in=4. After release: 2 writes, and the second is linear 2 with data 0xB.
- Head protection: waitrequest=1, push linear 3 (color 0x1), then linear 3 (color 0x2) → no merge, count=2. On release, two writes occur with data 0x1 then 0x2.
- Full with a same-cycle pop: FIFO full, waitrequest drops in the same cycle as in_valid → the beat is not accepted that cycle and is accepted the next cycle. The data order is preserved.
- Reset mid-stream: 5 entries queued, rst pulsed for 1 cycle → mem_write=0, idle=1, counters=0. The next push writes its own data with no stale entry.

Source files
------------

// File: rtl/gfx_defs.sv
// rtl/gfx_defs.sv - shared types and sizing for the framebuffer write path
`ifndef GFX_FB_ADDR_BITS
`define GFX_FB_ADDR_BITS 19
`endif

package gfx_defs;
  typedef logic [`GFX_FB_ADDR_BITS-1:0] linear_coord;
  typedef logic [31:0] rgb32;

  typedef struct packed {
    linear_coord linear;
    rgb32        color;
  } frag_paint;

  typedef struct packed {
    logic [31:0] addr;
    rgb32        color;
  } fb_entry;

  localparam int GFX_FB_WRITE_DEPTH = 8;
endpackage

// File: rtl/gfx_fb_write_fifo.sv
// rtl/gfx_fb_write_fifo.sv - circular entry buffer with tail overwrite for write merging
module gfx_fb_write_fifo
  import gfx_defs::*;
#(
  parameter int DEPTH = GFX_FB_WRITE_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int EW = $bits(fb_entry)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          overwrite,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] head,
  output logic [31:0]   tail_addr,
  output logic [PW:0]   count
);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] tail_ptr;
  fb_entry       tail_e;

  assign tail_ptr  = wr_ptr - 1'b1;
  assign head      = mem[rd_ptr];
  assign tail_e    = fb_entry'(mem[tail_ptr]);
  assign tail_addr = tail_e.addr;

  // Storage carries no reset; validity is defined entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end else if (overwrite) begin
      mem[tail_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gfx_fb_write.sv
// rtl/gfx_fb_write.sv - fragment paint sink issuing merged single-beat Avalon-MM framebuffer writes
module gfx_fb_write
  import gfx_defs::*;
#(
  parameter int DEPTH  = GFX_FB_WRITE_DEPTH,
  parameter int ADDR_W = `GFX_FB_ADDR_BITS,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$bits(frag_paint)-1:0] in,
  input  logic [31:0]                fb_base,
  output logic [31:0]                mem_address,
  output logic                       mem_write,
  output logic [31:0]                mem_writedata,
  output logic [3:0]                 mem_byteenable,
  input  logic                       mem_waitrequest,
  output logic                       idle,
  output logic [31:0]                frags_in,
  output logic [31:0]                writes_out
);

  frag_paint         frag;
  logic [ADDR_W-1:0] linear;
  logic [31:0]       push_addr;
  fb_entry           push_entry;
  fb_entry           head_e;
  logic [$bits(fb_entry)-1:0] head_bits;
  logic [31:0]       tail_addr;
  logic [PW:0]       count;
  logic              accept;
  logic              merge;
  logic              pop;

  assign frag   = frag_paint'(in);
  assign linear = frag.linear;

  // Byte address wraps modulo 2^32; fb_base is assumed word aligned.
  assign push_addr  = fb_base + {{(30-ADDR_W){1'b0}}, linear, 2'b00};
  assign push_entry = '{addr: push_addr, color: frag.color};

  assign in_ready = !rst && (count != (PW+1)'(DEPTH));
  assign accept   = in_valid && in_ready;
  // The head may already be on the bus, so merging needs at least two entries.
  assign merge    = accept && (count >= (PW+1)'(2)) && (tail_addr == push_addr);

  assign mem_write      = (count != '0);
  assign pop            = mem_write && !mem_waitrequest;
  assign head_e         = fb_entry'(head_bits);
  assign mem_address    = head_e.addr;
  assign mem_writedata  = head_e.color;
  assign mem_byteenable = 4'b1111;
  assign idle           = (count == '0);

  gfx_fb_write_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && !merge),
    .pop       (pop),
    .overwrite (merge),
    .wdata     (push_entry),
    .head      (head_bits),
    .tail_addr (tail_addr),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      frags_in   <= '0;
      writes_out <= '0;
    end else begin
      if (accept) frags_in   <= frags_in + 32'd1;
      if (pop)    writes_out <= writes_out + 32'd1;
    end
  end

endmodule
